// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared debounce state encoding and default settle length
package switch_pkg;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

   typedef enum logic [1:0] {
      STABLE_LOW   = 2'd0,
      RISE_PENDING = 2'd1,
      STABLE_HIGH  = 2'd2,
      FALL_PENDING = 2'd3
   } db_state_e;

endpackage

// File: rtl/switch_conditioner_if.sv
// rtl/switch_conditioner_if.sv - one push-button channel: raw level in, pulse and debounced level out
interface switch_conditioner_if;

   logic raw;
   logic pulse;
   logic lvl;

   modport master (output raw, input pulse, input lvl);
   modport slave  (input raw, output pulse, output lvl);

endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer, debounce FSM, settle counter and press pulse for one button
module debounce_channel
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   switch_conditioner_if.slave  btn
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // The change is accepted on the edge where the count would reach DEBOUNCE_CYCLES,
   // so the stored count tops out one below that and never wraps.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic      sync1_q, sync1_d;
   logic      sync2_q, sync2_d;
   db_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic      pulse_q, pulse_d;
   logic      lvl_q, lvl_d;

   // Next-state: two-flop synchronizer shift, then the debounce FSM acting on the synchronized sample.
   always_comb begin
      sync1_d = btn.raw;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      lvl_d   = lvl_q;
      case (state_q)
         STABLE_LOW: begin
            if (sync2_q) begin
               state_d = RISE_PENDING;
               cnt_d   = CW'(1);
            end
         end
         RISE_PENDING: begin
            if (!sync2_q) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
               lvl_d   = 1'b1;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STABLE_HIGH: begin
            if (!sync2_q) begin
               state_d = FALL_PENDING;
               cnt_d   = CW'(1);
            end
         end
         FALL_PENDING: begin
            if (sync2_q) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
               lvl_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // State register; reset aborts any pending debounce and clears the synchronizer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         lvl_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         lvl_q   <= lvl_d;
      end
   end

   assign btn.pulse = pulse_q;
   assign btn.lvl   = lvl_q;

endmodule

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - independent debounce of the on and off push-buttons
module switch_conditioner
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic BTN_ON_RAW,
   input  logic BTN_OFF_RAW,
   output logic SW_ON,
   output logic SW_OFF,
   output logic BTN_ON_LVL,
   output logic BTN_OFF_LVL
);

   switch_conditioner_if on_if ();
   switch_conditioner_if off_if ();

   assign on_if.raw  = BTN_ON_RAW;
   assign off_if.raw = BTN_OFF_RAW;

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_on (
      .clk   (CLK),
      .rst_n (RST_N),
      .btn   (on_if)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_off (
      .clk   (CLK),
      .rst_n (RST_N),
      .btn   (off_if)
   );

   assign SW_ON       = on_if.pulse;
   assign SW_OFF      = off_if.pulse;
   assign BTN_ON_LVL  = on_if.lvl;
   assign BTN_OFF_LVL = off_if.lvl;

endmodule

// File: tb/tb_switch_conditioner.sv
// tb/tb_switch_conditioner.sv - scoreboard bench for switch_conditioner with run-length reference model
module tb_switch_conditioner;

   localparam int D = 4;

   typedef struct {
      int   edge_no;
      logic on_p;
      logic off_p;
      logic on_l;
      logic off_l;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   switch_conditioner_if on_bus ();
   switch_conditioner_if off_bus ();

   switch_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .BTN_ON_RAW  (on_bus.raw),
      .BTN_OFF_RAW (off_bus.raw),
      .SW_ON       (on_bus.pulse),
      .SW_OFF      (off_bus.pulse),
      .BTN_ON_LVL  (on_bus.lvl),
      .BTN_OFF_LVL (off_bus.lvl)
   );

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   step_idx = 0;
   int   edge_idx = 0;
   int   on_edges[$];
   int   off_edges[$];

   // reference model: inputs seen two edges late; a level flips after D consecutive differing samples
   logic dq_on[$];
   logic dq_off[$];
   int   run_on, run_off;
   logic lvl_on, lvl_off;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s at edge %0d: actual %0d required %0d", name, edge_idx, act, req);
      end
   endtask

   task automatic chan(input logic s, inout int run, inout logic lvl, output logic p);
      p = 1'b0;
      if (s != lvl) begin
         run++;
         if (run == D) begin
            lvl = s;
            run = 0;
            p   = s;
         end
      end else begin
         run = 0;
      end
   endtask

   task automatic step(input logic r, input logic on, input logic off);
      exp_t e;
      logic s_on, s_off;
      rst_n       = r;
      on_bus.raw  = on;
      off_bus.raw = off;
      e.edge_no   = step_idx;
      if (!r) begin
         dq_on   = {1'b0, 1'b0};
         dq_off  = {1'b0, 1'b0};
         run_on  = 0;
         run_off = 0;
         lvl_on  = 1'b0;
         lvl_off = 1'b0;
         e.on_p  = 1'b0;
         e.off_p = 1'b0;
      end else begin
         s_on  = dq_on.pop_front();
         s_off = dq_off.pop_front();
         dq_on.push_back(on);
         dq_off.push_back(off);
         chan(s_on, run_on, lvl_on, e.on_p);
         chan(s_off, run_off, lvl_off, e.off_p);
      end
      e.on_l  = lvl_on;
      e.off_l = lvl_off;
      sb.push_back(e);
      step_idx++;
      @(negedge clk);
   endtask

   // monitor: one output sample per edge, compared against the oldest scoreboard entry
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            check("scoreboard_underflow", 0, 1);
         end else begin
            e = sb.pop_front();
            check("edge_align", edge_idx, e.edge_no);
            check("sw_on", int'(on_bus.pulse), int'(e.on_p));
            check("sw_off", int'(off_bus.pulse), int'(e.off_p));
            check("btn_on_lvl", int'(on_bus.lvl), int'(e.on_l));
            check("btn_off_lvl", int'(off_bus.lvl), int'(e.off_l));
         end
         if (on_bus.pulse === 1'b1) on_edges.push_back(edge_idx);
         if (off_bus.pulse === 1'b1) off_edges.push_back(edge_idx);
         edge_idx++;
      end
   end

   initial begin
      int   rise;
      logic ron, roff;
      dq_on  = {1'b0, 1'b0};
      dq_off = {1'b0, 1'b0};
      run_on = 0; run_off = 0; lvl_on = 1'b0; lvl_off = 1'b0;

      repeat (3) step(1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0);

      // clean press: pulse 1+D edges after the first sampling edge
      on_edges.delete();
      rise = step_idx;
      repeat (10) step(1'b1, 1'b1, 1'b0);
      check("press_pulse_count", on_edges.size(), 1);
      if (on_edges.size() > 0) check("press_latency", on_edges[0] - rise, 1 + D);

      // release: level falls, no new pulse
      repeat (8) step(1'b1, 1'b0, 1'b0);
      check("release_no_pulse", on_edges.size(), 1);

      // bounce on the off button, then a held press
      off_edges.delete();
      repeat (2) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      rise = step_idx;
      repeat (10) step(1'b1, 1'b0, 1'b1);
      check("bounce_pulse_count", off_edges.size(), 1);
      if (off_edges.size() > 0) check("bounce_latency", off_edges[0] - rise, 1 + D);
      repeat (8) step(1'b1, 1'b0, 1'b0);

      // simultaneous press
      on_edges.delete();
      off_edges.delete();
      repeat (10) step(1'b1, 1'b1, 1'b1);
      check("simul_on_count", on_edges.size(), 1);
      check("simul_off_count", off_edges.size(), 1);
      if (on_edges.size() > 0 && off_edges.size() > 0)
         check("simul_same_edge", on_edges[0], off_edges[0]);
      repeat (8) step(1'b1, 1'b0, 1'b0);

      // reset while the counter holds 3, button still held
      on_edges.delete();
      repeat (5) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      rise = step_idx;
      repeat (10) step(1'b1, 1'b1, 1'b0);
      check("reset_mid_count", on_edges.size(), 1);
      if (on_edges.size() > 0) check("reset_mid_latency", on_edges[0] - rise, 1 + D);
      repeat (8) step(1'b1, 1'b0, 1'b0);

      // long hold
      on_edges.delete();
      repeat (100) step(1'b1, 1'b1, 1'b0);
      check("hold_pulse_count", on_edges.size(), 1);
      repeat (8) step(1'b1, 1'b0, 1'b0);

      // randomized bouncing with occasional resets
      ron = 1'b0;
      roff = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) ron = ~ron;
         if ($urandom_range(0, 5) == 0) roff = ~roff;
         step(($urandom_range(0, 199) != 0), ron, roff);
      end

      check("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port BTN_ON_RAW  input  1  raw asynchronous "on" push-button, bouncy, active-high.
REQ-005 SHALL have port BTN_OFF_RAW  input  1  raw asynchronous "off" push-button, bouncy, active-high.
REQ-006 SHALL have port SW_ON  output  1  registered one-cycle pulse on each debounced press of the "on" button.
REQ-007 SHALL have port SW_OFF  output  1  registered one-cycle pulse on each debounced press of the "off" button.
REQ-008 SHALL have port BTN_ON_LVL  output  1  debounced level of the "on" button.
REQ-009 SHALL have port BTN_OFF_LVL  output  1  debounced level of the "off" button.

Function
REQ-010 SHALL process each button in an independent, identical channel; the channels share no state.
REQ-011 SHALL pass each raw input through a 2-flop synchronizer before any other logic uses it.
REQ-012 SHALL run a per-channel FSM with states STABLE_LOW, RISE_PENDING, STABLE_HIGH and FALL_PENDING.
REQ-013 SHALL move STABLE_LOW->RISE_PENDING when the synchronized sample is 1, and STABLE_HIGH->FALL_PENDING when it is 0; the counter loads 1 on that edge.
REQ-014 SHALL, in a *_PENDING state, increment the counter on each edge where the sample still differs from the stable level.
REQ-015 SHALL return to the originating STABLE state and clear the counter to 0 if the sample matches the stable level before the count reaches DEBOUNCE_CYCLES; no pulse and no level change occur.
REQ-016 SHALL enter the opposite STABLE state on the edge where the count reaches DEBOUNCE_CYCLES, update *_LVL and clear the counter on that same edge.
REQ-017 SHALL assert SW_ON/SW_OFF on the same edge that the FSM enters STABLE_HIGH, and deassert it on the next edge (exactly one cycle).
REQ-018 SHALL produce no pulse when entering STABLE_LOW (release), and the *_LVL output falls on that edge.
REQ-019 SHALL give a latency of 1+DEBOUNCE_CYCLES edges: a raw rise first sampled at edge k yields a pulse and level high from edge k+1+DEBOUNCE_CYCLES.
REQ-020 SHALL size the counter as $clog2(DEBOUNCE_CYCLES+1) bits; the counter never exceeds DEBOUNCE_CYCLES and never wraps.
REQ-021 SHALL report simultaneous presses independently: SW_ON and SW_OFF may be high in the same cycle, with no arbitration in this block.
REQ-022 SHALL, after reset release with a button held high, treat the button as a new press and pulse after the normal latency.

Reset
REQ-023 SHALL, while RST_N=0 at a rising CLK edge, clear both synchronizer flops, set FSM=STABLE_LOW, counter=0, SW_ON=SW_OFF=0 and BTN_ON_LVL=BTN_OFF_LVL=0.
REQ-024 SHALL abort any pending debounce when reset is asserted mid-operation; no pulse is emitted during or on exit from reset.
REQ-025 SHALL use no asynchronous reset paths.

Structure
REQ-026 SHALL place the debounce FSM state enum and the default DEBOUNCE_CYCLES constant in shared package switch_pkg.
REQ-027 SHALL implement one channel (synchronizer, FSM, counter, pulse register) as sub-module debounce_channel, instantiated twice.
REQ-028 SHALL register all outputs, with no combinational path from input to output.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Clean press: BTN_ON_RAW 0->1 before edge 0 and held -> SW_ON=1 only in the cycle after edge 5, BTN_ON_LVL=1 from edge 5.
REQ-030 Bounce reject: BTN_OFF_RAW high for 2 cycles, low for 1, then high and held -> exactly one SW_OFF pulse, 5 edges after the final rise is sampled.
REQ-031 Release: with the button held stable-high, drop it -> BTN_ON_LVL falls 5 edges later and SW_ON stays 0.
REQ-032 Simultaneous press: both raw inputs rise on the same cycle -> SW_ON and SW_OFF both pulse in the same single cycle.
REQ-033 Reset mid-debounce: RST_N=0 for 1 cycle at counter=3 -> no pulse, outputs 0; the still-held button pulses 5 edges after reset release.
REQ-034 Hold check: press held for 100 cycles -> exactly one SW_ON pulse, with BTN_ON_LVL high throughout after acceptance.
